fpga_sys_reset_exit_ctrl: RTL



---
 rtl/fpga_sys_ctrl_pkg.sv | 35 +++
 rtl/fpga_btn_debounce.sv | 54 +++++
 rtl/fpga_sync_2ff.sv | 33 +++
 rtl/fpga_sys_reset_exit_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_sys_ctrl_pkg.sv
// rtl/fpga_sys_ctrl_pkg.sv - shared types and constants for the FPGA system reset/exit controller
package fpga_sys_ctrl_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2,
    EXITED    = 2'd3
  } sys_state_e;

  typedef enum logic [1:0] {
    BLINK_ON  = 2'd0,
    BLINK_OFF = 2'd1,
    BLINK_GAP = 2'd2
  } blink_phase_e;

  // Gap between blink groups, in units of one half-period.
  localparam int GAP_MULT = 4;
  // Number of exit-code bits shown as a pulse count.
  localparam int EXIT_BLINK_BITS = 4;

  // SoC reset is released in both RUN and EXITED.
  function automatic logic soc_released(input sys_state_e s);
    return (s == RUN) || (s == EXITED);
  endfunction

  // Index of the last pulse in a group; a zero field means a full group of 2**EXIT_BLINK_BITS pulses.
  function automatic logic [EXIT_BLINK_BITS-1:0] blink_last_pulse(input logic [EXIT_BLINK_BITS-1:0] n);
    if (n == '0) begin
      return '1;
    end
    return n - 1'b1;
  endfunction

endpackage

// File: rtl/fpga_btn_debounce.sv
// rtl/fpga_btn_debounce.sv - push-button debouncer producing a stable pressed level and a press pulse
module fpga_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BTN_ACTIVE_LOW  = 0
) (
  input  logic clk_gen,
  input  logic rst_n,
  input  logic level_i,
  output logic stable_o,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             pressed_lvl;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;

  // Count consecutive cycles the input disagrees with the accepted level; accept after the full window.
  always_comb begin
    pressed_lvl = (BTN_ACTIVE_LOW != 0) ? ~level_i : level_i;
    cnt_d       = cnt_q;
    stable_d    = stable_q;
    press_d     = 1'b0;
    if (pressed_lvl == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      cnt_d    = '0;
      stable_d = pressed_lvl;
      press_d  = pressed_lvl;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state; accepted level starts as "not pressed".
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule

// File: rtl/fpga_sync_2ff.sv
// rtl/fpga_sync_2ff.sv - shared two-flop synchronizer cell for asynchronous single-bit inputs
module fpga_sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk_gen,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Shift the raw level through two flops.
  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  // Synchronizer flops, reset to the idle level of the input.
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fpga_sys_reset_exit_ctrl.sv
// rtl/fpga_sys_reset_exit_ctrl.sv - SoC reset sequencer with exit-code capture and LED reporting
module fpga_sys_reset_exit_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int RST_HOLD_CYCLES   = 256,
  parameter int BLINK_HALF_CYCLES = 12500000,
  parameter int HEARTBEAT_W       = 27,
  parameter int BTN_ACTIVE_LOW    = 0
) (
  input  logic        clk_gen,
  input  logic        rst_n,
  input  logic        rst_btn_i,
  input  logic        pll_locked_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        sys_rst_no,
  output logic        run_led_o,
  output logic        exit_led_o,
  output logic        heartbeat_led_o,
  output logic [31:0] exit_code_o
);

  import fpga_sys_ctrl_pkg::*;

  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam int BLINK_GAP_CYCLES = GAP_MULT * BLINK_HALF_CYCLES;
  localparam int BLINK_W = $clog2(BLINK_GAP_CYCLES + 1);
  localparam logic [BLINK_W-1:0] HALF_LAST = BLINK_W'(BLINK_HALF_CYCLES - 1);
  localparam logic [BLINK_W-1:0] GAP_LAST  = BLINK_W'(BLINK_GAP_CYCLES - 1);

  logic btn_s, lock_s, exit_valid_s, btn_press;

  sys_state_e                 state_q, state_d;
  logic [HOLD_W-1:0]          hold_cnt_q, hold_cnt_d;
  logic [31:0]                exit_code_q, exit_code_d;
  logic                       sys_rst_no_q, sys_rst_no_d;
  logic                       run_led_q, run_led_d;
  logic [HEARTBEAT_W-1:0]     hb_cnt_q, hb_cnt_d;
  blink_phase_e               blink_phase_q, blink_phase_d;
  logic [BLINK_W-1:0]         blink_cnt_q, blink_cnt_d;
  logic [EXIT_BLINK_BITS-1:0] pulse_idx_q, pulse_idx_d;
  logic                       exit_led_q, exit_led_d;

  fpga_sync_2ff #(.RESET_VAL(BTN_ACTIVE_LOW != 0)) u_sync_btn (
    .clk_gen (clk_gen),
    .rst_n   (rst_n),
    .d_i     (rst_btn_i),
    .q_o     (btn_s)
  );

  fpga_sync_2ff #(.RESET_VAL(1'b0)) u_sync_lock (
    .clk_gen (clk_gen),
    .rst_n   (rst_n),
    .d_i     (pll_locked_i),
    .q_o     (lock_s)
  );

  fpga_sync_2ff #(.RESET_VAL(1'b0)) u_sync_exit (
    .clk_gen (clk_gen),
    .rst_n   (rst_n),
    .d_i     (exit_valid_i),
    .q_o     (exit_valid_s)
  );

  fpga_btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_debounce (
    .clk_gen  (clk_gen),
    .rst_n    (rst_n),
    .level_i  (btn_s),
    .stable_o (),
    .press_o  (btn_press)
  );

  // Next state: lock loss beats a press, a press beats the per-state rule.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    exit_code_d = exit_code_q;
    if ((state_q != WAIT_LOCK) && !lock_s) begin
      state_d = WAIT_LOCK;
    end else if (btn_press && lock_s) begin
      state_d     = HOLD;
      hold_cnt_d  = '0;
      exit_code_d = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d     = HOLD;
            hold_cnt_d  = '0;
            exit_code_d = '0;
          end
        end
        HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = RUN;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (exit_valid_s) begin
            state_d     = EXITED;
            exit_code_d = exit_value_i;
          end
        end
        EXITED: begin
          state_d = EXITED;
        end
        default: begin
          state_d = WAIT_LOCK;
        end
      endcase
    end
    if (state_d != HOLD) begin
      hold_cnt_d = '0;
    end
  end

  // Outputs are derived from the next state so they change together with it.
  always_comb begin
    sys_rst_no_d = soc_released(state_d);
    run_led_d    = (state_d == RUN);
    if (soc_released(state_d) && soc_released(state_q)) begin
      hb_cnt_d = (hb_cnt_q == '1) ? '0 : hb_cnt_q + 1'b1;
    end else begin
      hb_cnt_d = '0;
    end
  end

  // Blink engine: ON/OFF per pulse, then a long gap; starts lit on the first EXITED cycle.
  always_comb begin
    blink_phase_d = blink_phase_q;
    blink_cnt_d   = blink_cnt_q;
    pulse_idx_d   = pulse_idx_q;
    exit_led_d    = 1'b0;
    if (state_d != EXITED) begin
      blink_phase_d = BLINK_ON;
      blink_cnt_d   = '0;
      pulse_idx_d   = '0;
    end else if ((state_q != EXITED) || (exit_code_d == '0)) begin
      blink_phase_d = BLINK_ON;
      blink_cnt_d   = '0;
      pulse_idx_d   = '0;
      exit_led_d    = 1'b1;
    end else begin
      case (blink_phase_q)
        BLINK_ON: begin
          if (blink_cnt_q >= HALF_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = BLINK_OFF;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
        BLINK_OFF: begin
          if (blink_cnt_q >= HALF_LAST) begin
            blink_cnt_d = '0;
            if (pulse_idx_q == blink_last_pulse(exit_code_q[EXIT_BLINK_BITS-1:0])) begin
              pulse_idx_d   = '0;
              blink_phase_d = BLINK_GAP;
            end else begin
              pulse_idx_d   = pulse_idx_q + 1'b1;
              blink_phase_d = BLINK_ON;
            end
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
        BLINK_GAP: begin
          if (blink_cnt_q >= GAP_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = BLINK_ON;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
        default: begin
          blink_cnt_d   = '0;
          pulse_idx_d   = '0;
          blink_phase_d = BLINK_ON;
        end
      endcase
      exit_led_d = (blink_phase_d == BLINK_ON);
    end
  end

  // Controller registers, all cleared by the global reset.
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_LOCK;
      hold_cnt_q    <= '0;
      exit_code_q   <= '0;
      sys_rst_no_q  <= 1'b0;
      run_led_q     <= 1'b0;
      hb_cnt_q      <= '0;
      blink_phase_q <= BLINK_ON;
      blink_cnt_q   <= '0;
      pulse_idx_q   <= '0;
      exit_led_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      exit_code_q   <= exit_code_d;
      sys_rst_no_q  <= sys_rst_no_d;
      run_led_q     <= run_led_d;
      hb_cnt_q      <= hb_cnt_d;
      blink_phase_q <= blink_phase_d;
      blink_cnt_q   <= blink_cnt_d;
      pulse_idx_q   <= pulse_idx_d;
      exit_led_q    <= exit_led_d;
    end
  end

  assign sys_rst_no      = sys_rst_no_q;
  assign run_led_o       = run_led_q;
  assign exit_led_o      = exit_led_q;
  assign heartbeat_led_o = hb_cnt_q[HEARTBEAT_W-1];
  assign exit_code_o     = exit_code_q;

endmodule
